timer_cfg_seq: RTL and testbench
================================

Name: timer_cfg_seq

Overview:
Command sequencer that sits directly upstream of the timer core. It accepts one timer job per valid/ready handshake: period, duty and repeat count. It programs the three timer registers over the timer's write port (we/addr/wdata), pulses the timer start input, then waits for the timer-end indication. It reports completion, timeout or parameter error to the system controller.

Parameters:
DW, 16, width of timer write data and job fields
START_LEN, 1, number of cycles o_start is held high (1..15)
TO_W, 24, width of the wait-for-end timeout counter
TIMEOUT, 24'd100000, cycles allowed in WAIT before declaring timeout; 0 disables timeout

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  job request valid
o_cmd_ready  out  1  high only in IDLE
i_period  in  DW  timer period, written to timer addr 0
i_duty  in  DW  timer high time, written to timer addr 1
i_count  in  DW  timer repeat count, written to timer addr 2
i_abort  in  1  cancel current job
i_timer_end  in  1  end indication from timer (o_timer_end)
o_we  out  1  timer register write enable
o_addr  out  2  timer register address
o_wdata  out  DW  timer register write data
o_start  out  1  timer start pulse
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse: job ended normally
o_err  out  1  one-cycle pulse: job rejected
o_timeout  out  1  one-cycle pulse: timer end never seen

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- All outputs are registered. Reset values: all outputs 0 except o_cmd_ready=1. State resets to IDLE. Shadow registers and counters reset to 0.
- States: IDLE, WR_PER, WR_DUTY, WR_CNT, START, WAIT, DONE.
- IDLE:
  - Accept on i_cmd_valid & o_cmd_ready (edge N). Capture i_period, i_duty and i_count into shadow registers.
  - Reject if i_period==0 or i_duty>i_period (unsigned). On reject: o_err=1 during cycle N+1, stay in IDLE, o_cmd_ready stays 1.
  - Otherwise go to WR_PER.
- WR_PER / WR_DUTY / WR_CNT: one cycle each.
  - o_we=1, o_addr=0/1/2, o_wdata=shadow period/duty/count.
  - Visible in cycles N+1, N+2, N+3.
  - o_we=0 and o_wdata=0 in all other states.
  - o_addr holds 0 outside the write states.
- START: o_start=1 for exactly START_LEN cycles, starting at cycle N+4. The internal counter is cleared on entry. Then go to WAIT.
- WAIT:
  - i_timer_end is sampled only in WAIT. Any assertion in earlier states is ignored.
  - i_timer_end=1 -> DONE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 (TIMEOUT≠0): o_timeout pulses 1 cycle and the FSM returns to IDLE.
  - The counter saturates and never wraps. It clears on entry to WAIT.
- DONE: o_done=1 for one cycle, then IDLE. o_cmd_ready is high again the cycle after DONE.
- i_abort:
  - In any non-IDLE state, the next state is IDLE.
  - o_we and o_start are forced 0 from the next cycle.
  - No o_done, o_err or o_timeout pulse is produced.
  - i_abort has priority over i_timer_end and timeout in the same cycle.
  - i_abort in IDLE has no effect and does not block acceptance.
- i_cmd_valid while busy: ignored (ready=0). The job must be held by the requester.
- Simultaneous i_timer_end and timeout in the same WAIT cycle: i_timer_end wins (o_done, no o_timeout).
- Reset asserted mid-job: immediate return to the reset values. The timer may be left partially programmed, which is acceptable.
- Only one of o_done, o_err, o_timeout is ever high in a given cycle.

Test Plan:
- Normal job. Reset release, then job period=20, duty=10, count=2.
  - Required writes (addr,data): (0,20), (1,10), (2,2) on consecutive cycles N+1..N+3.
  - o_start high at N+4 only.
  - Model i_timer_end 30 cycles later -> o_done one cycle, o_cmd_ready=1 the cycle after.
- Reject cases, each accepted for one cycle only, then o_err=1 for one cycle, o_we never asserts, FSM stays in IDLE:
  - duty=25, period=20.
  - period=0.
- Timeout. TIMEOUT=50, i_timer_end held low. Expected: o_timeout at WAIT entry +49 cycles, no o_done, back in IDLE, next job accepted.
- Abort during write and during wait:
  - i_abort at N+2 -> only the (0,20) and (1,10) writes occur, no o_start.
  - i_abort in WAIT together with i_timer_end -> no o_done.
  - o_busy falls the cycle after abort.
- Stray end and back-to-back jobs:
  - i_timer_end pulsed during WR_DUTY -> ignored, FSM still reaches WAIT.
  - Second job with period=40, duty=5, count=1 held valid during the first job -> accepted only after DONE, writes (0,40), (1,5), (2,1).
- Async reset mid-WAIT: i_rst_n low for 3ns between edges -> all outputs go to reset values immediately, o_cmd_ready=1.

Source files
------------

// File: rtl/timer_cfg_seq.sv
// Timer job sequencer: programs period, duty and repeat count into the timer,
// pulses start, then waits for the end indication or a timeout.
module timer_cfg_seq #(
    parameter int              DW        = 16,
    parameter int              START_LEN = 1,
    parameter int              TO_W      = 24,
    parameter logic [TO_W-1:0] TIMEOUT   = 24'd100000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [DW-1:0] i_period,
    input  logic [DW-1:0] i_duty,
    input  logic [DW-1:0] i_count,
    input  logic          i_abort,
    input  logic          i_timer_end,
    output logic          o_we,
    output logic [1:0]    o_addr,
    output logic [DW-1:0] o_wdata,
    output logic          o_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PER,
        S_WR_DUTY,
        S_WR_CNT,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0]  START_LAST = 4'(START_LEN - 1);
    localparam logic [TO_W:0] TO_ONE   = {{TO_W{1'b0}}, 1'b1};
    localparam logic [TO_W:0] TO_LAST  = {1'b0, TIMEOUT} - TO_ONE;

    state_t          state_q, state_d;
    logic [DW-1:0]   duty_q, count_q;
    logic [3:0]      start_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W:0]   to_next;

    logic            accept, reject, to_hit;
    logic            we_d, start_d, done_d, err_d, timeout_d;
    logic [1:0]      addr_d;
    logic [DW-1:0]   wdata_d;

    // Outputs are registered, so the pulse is raised on the edge where the
    // counter steps onto TIMEOUT-1; the extra bit keeps the compare wrap-free.
    assign to_next = {1'b0, to_cnt_q} + TO_ONE;
    assign to_hit  = (TIMEOUT != '0) && (to_next >= TO_LAST);
    assign accept  = (state_q == S_IDLE) && i_cmd_valid && o_cmd_ready;
    assign reject  = (i_period == '0) || (i_duty > i_period);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) err_d   = 1'b1;
                    else        state_d = S_WR_PER;
                end
            end
            S_WR_PER:  state_d = S_WR_DUTY;
            S_WR_DUTY: state_d = S_WR_CNT;
            S_WR_CNT:  state_d = S_START;
            S_START: begin
                if (start_cnt_q == START_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_timer_end) begin
                    state_d = S_DONE;
                end else if (to_hit) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (i_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
        end

        // Registered outputs follow the state being entered.
        we_d    = 1'b0;
        addr_d  = 2'd0;
        wdata_d = '0;
        case (state_d)
            S_WR_PER: begin
                // Entered only from an accept, so the period comes straight
                // off the request bus; o_wdata itself is its shadow copy.
                we_d    = 1'b1;
                wdata_d = i_period;
            end
            S_WR_DUTY: begin
                we_d    = 1'b1;
                addr_d  = 2'd1;
                wdata_d = duty_q;
            end
            S_WR_CNT: begin
                we_d    = 1'b1;
                addr_d  = 2'd2;
                wdata_d = count_q;
            end
            default: ;
        endcase
        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            duty_q      <= '0;
            count_q     <= '0;
            start_cnt_q <= '0;
            to_cnt_q    <= '0;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_we        <= 1'b0;
            o_addr      <= 2'd0;
            o_wdata     <= '0;
            o_start     <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                duty_q  <= i_duty;
                count_q <= i_count;
            end

            if ((state_q == S_START) && (state_d == S_START))
                start_cnt_q <= start_cnt_q + 4'd1;
            else
                start_cnt_q <= '0;

            // Saturates at all-ones rather than wrapping back to zero.
            if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
                if (!to_next[TO_W]) to_cnt_q <= to_next[TO_W-1:0];
            end else begin
                to_cnt_q <= '0;
            end

            o_cmd_ready <= (state_d == S_IDLE);
            o_busy      <= (state_d != S_IDLE);
            o_we        <= we_d;
            o_addr      <= addr_d;
            o_wdata     <= wdata_d;
            o_start     <= start_d;
            o_done      <= done_d;
            o_err       <= err_d;
            o_timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_timer_cfg_seq.sv
// Scoreboard bench for timer_cfg_seq: expected timer writes and status pulses
// are queued when a job is driven and matched as the DUT emits them.
module tb_timer_cfg_seq;

    localparam int DW = 16;
    localparam int TO = 50;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic [DW-1:0] i_period = '0, i_duty = '0, i_count = '0;
    logic          i_abort = 1'b0, i_timer_end = 1'b0;
    logic          o_cmd_ready, o_we, o_start, o_busy, o_done, o_err, o_timeout;
    logic [1:0]    o_addr;
    logic [DW-1:0] o_wdata;

    timer_cfg_seq #(.DW(DW), .START_LEN(1), .TO_W(24), .TIMEOUT(24'd50)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_period(i_period), .i_duty(i_duty), .i_count(i_count),
        .i_abort(i_abort), .i_timer_end(i_timer_end),
        .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata), .o_start(o_start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef enum logic [2:0] {EV_NONE, EV_WR, EV_START, EV_DONE, EV_ERR, EV_TO} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [31:0] at;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  e = 0;
    int  job_n = 0, job_end = 0;
    bit  job_live = 1'b0;

    always @(posedge i_clk) e <= e + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, got, want, e);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [1:0] a, input logic [15:0] d, input int at);
        exp_q.push_back('{kind: k, addr: a, data: d, at: 32'(at)});
    endtask

    task automatic drop_from(input int at);
        ev_t keep[$];
        foreach (exp_q[i]) if (int'(exp_q[i].at) < at) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    task automatic observe(input string tag, input ev_kind_t k, input logic [1:0] a, input logic [15:0] d);
        ev_t o, x;
        o = '{kind: k, addr: a, data: d, at: 32'(e)};
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'(o), 64'd0);
        end else begin
            x = exp_q.pop_front();
            check(tag, 64'(o), 64'(x));
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_we) observe("write", EV_WR, o_addr, o_wdata);
            else      check("bus_idle", 64'({o_addr, o_wdata}), 64'd0);
            if (o_start)   observe("start", EV_START, 2'd0, 16'd0);
            if (o_done)    observe("done", EV_DONE, 2'd0, 16'd0);
            if (o_err)     observe("err", EV_ERR, 2'd0, 16'd0);
            if (o_timeout) observe("timeout", EV_TO, 2'd0, 16'd0);
        end
    end

    // Inputs change 2 ns after the rising edge; the next edge samples them.
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic send_job(input logic [15:0] p, input logic [15:0] d, input logic [15:0] c,
                            output int n);
        n = -1;
        i_period = p; i_duty = d; i_count = c; i_cmd_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (o_cmd_ready) begin
                n = e + 1;
                if (p == 16'd0 || d > p) begin
                    push_ev(EV_ERR, 2'd0, 16'd0, n);
                end else begin
                    push_ev(EV_WR, 2'd0, p, n);
                    push_ev(EV_WR, 2'd1, d, n + 1);
                    push_ev(EV_WR, 2'd2, c, n + 2);
                    push_ev(EV_START, 2'd0, 16'd0, n + 3);
                    push_ev(EV_TO, 2'd0, 16'd0, n + 3 + TO);
                    job_n = n; job_end = n + 3 + TO; job_live = 1'b1;
                end
                step(1);
                i_cmd_valid = 1'b0;
                return;
            end
            step(1);
        end
        i_cmd_valid = 1'b0;
        check("accept_wait", 64'd0, 64'd1);
    endtask

    task automatic pulse_end();
        int x;
        x = e + 1;
        if (job_live && x >= job_n + 5 && x <= job_end) begin
            drop_from(x);
            push_ev(EV_DONE, 2'd0, 16'd0, x);
            job_end = x; job_live = 1'b0;
        end
        i_timer_end = 1'b1;
        step(1);
        i_timer_end = 1'b0;
    endtask

    task automatic abort_now(input bit with_end);
        int a;
        a = e + 1;
        if (job_live && a > job_n && a <= job_end) begin
            drop_from(a);
            job_live = 1'b0;
        end
        i_abort = 1'b1; i_timer_end = with_end;
        step(1);
        i_abort = 1'b0; i_timer_end = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, x_end;

        // Reset values.
        step(2);
        check("reset_outs", 64'({o_cmd_ready, o_busy, o_we, o_addr, o_wdata, o_start,
                                 o_done, o_err, o_timeout}), 64'({1'b1, 24'd0}));
        i_rst_n = 1'b1;
        step(2);

        // Normal job, end 30 cycles after the start pulse.
        send_job(16'd20, 16'd10, 16'd2, n);
        check("busy_job", 64'(o_busy), 64'd1);
        step(32);
        pulse_end();
        check("ready_in_done", 64'(o_cmd_ready), 64'd0);
        step(1);
        check("ready_after_done", 64'(o_cmd_ready), 64'd1);
        check_drained("drain_normal");

        // Rejects: duty above period, then zero period.
        send_job(16'd20, 16'd25, 16'd3, n);
        check("ready_rej1", 64'({o_cmd_ready, o_busy}), 64'b10);
        step(2);
        check_drained("drain_rej1");
        send_job(16'd0, 16'd0, 16'd1, n);
        check("ready_rej2", 64'({o_cmd_ready, o_busy}), 64'b10);
        step(2);
        check_drained("drain_rej2");

        // Timeout with the end indication held low, then a fresh job.
        send_job(16'd7, 16'd3, 16'd1, n);
        step(58);
        check("ready_after_to", 64'(o_cmd_ready), 64'd1);
        check_drained("drain_timeout");
        send_job(16'd9, 16'd9, 16'd3, n);
        step(6);
        pulse_end();
        step(2);
        check_drained("drain_after_to");

        // Abort in WR_DUTY: only the first two writes, no start.
        send_job(16'd20, 16'd10, 16'd2, n);
        step(1);
        check("busy_pre_abort", 64'(o_busy), 64'd1);
        abort_now(1'b0);
        check("busy_post_abort", 64'(o_busy), 64'd0);
        step(3);
        check_drained("drain_abort_wr");

        // Abort in WAIT together with the end indication.
        send_job(16'd20, 16'd10, 16'd2, n);
        step(10);
        abort_now(1'b1);
        check("busy_abort_wait", 64'(o_busy), 64'd0);
        step(2);
        check_drained("drain_abort_wait");

        // Stray end during WR_DUTY, second job held valid throughout.
        send_job(16'd20, 16'd10, 16'd2, n);
        x_end = 0;
        fork
            begin
                step(1);
                pulse_end();
                step(10);
                x_end = e + 1;
                pulse_end();
            end
            begin
                step(1);
                send_job(16'd40, 16'd5, 16'd1, n2);
            end
        join
        check("b2b_accept_edge", 64'(n2), 64'(x_end + 2));
        step(6);
        pulse_end();
        step(2);
        check_drained("drain_b2b");

        // Asynchronous reset pulse while waiting for the timer.
        send_job(16'd20, 16'd10, 16'd2, n);
        step(8);
        #1 i_rst_n = 1'b0;
        #1;
        check("async_reset", 64'({o_cmd_ready, o_busy, o_we, o_addr, o_wdata, o_start,
                                  o_done, o_err, o_timeout}), 64'({1'b1, 24'd0}));
        exp_q.delete();
        job_live = 1'b0;
        #2 i_rst_n = 1'b1;
        step(1);
        check("ready_post_reset", 64'({o_cmd_ready, o_busy}), 64'b10);
        send_job(16'd5, 16'd0, 16'd4, n);
        step(6);
        pulse_end();
        step(2);
        check_drained("drain_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
